// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2
// Description : Two-master Wishbone arbiter placed in front of the peripheral
//               crossbar master port. m0 is the CPU xbus and m1 is a
//               DMA/streaming master. Round-robin grant is held for the
//               whole bus cycle, so the bus is only re-arbitrated once the
//               owner drops cyc.
//               Optional feature macro: WB_ARB_TIMEOUT_EN. When it is defined,
//               a stuck-slave timeout returns a one-cycle err to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          FIRST_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (CPU xbus)
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_o,
    output logic [31:0] m0_dat_i,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic        m0_stb,
    input  logic        m0_cyc,
    output logic        m0_ack,
    output logic        m0_err,
    // master 1 (DMA / streaming)
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_o,
    output logic [31:0] m1_dat_i,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic        m1_stb,
    input  logic        m1_cyc,
    output logic        m1_ack,
    output logic        m1_err,
    // single slave side (crossbar)
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic        s_stb,
    output logic        s_cyc,
    input  logic        s_ack,
    // status
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_owner;
    logic        w_last_owner_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        w_owner_stb;
    logic        w_timeout_hit;

    // A zero timeout would raise err on the very first beat of every access.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT_CYCLES must be at least 1");
    end

    // State, round-robin history and registered grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= ~FIRST_PRIO;
            r_grant      <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_grant      <= w_grant_nxt;
        end
    end

    // Next-state logic: arbitrate only from IDLE and release when cyc drops.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    // Both are requesting, so hand the bus to whoever did not own it last.
                    w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_cyc) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_owner_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_grant_nxt = {(w_state_nxt == ST_OWN1), (w_state_nxt == ST_OWN0)};
    end

    // Owner's strobe qualified by its cyc; a strobe without cyc is not a request.
    always_comb begin
        w_owner_stb = 1'b0;
        case (r_state)
            ST_OWN0: w_owner_stb = m0_stb & m0_cyc;
            ST_OWN1: w_owner_stb = m1_stb & m1_cyc;
            default: w_owner_stb = 1'b0;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned          c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_to_cnt;

    // The slave ack always takes precedence over a timeout in the same cycle.
    assign w_timeout_hit = w_owner_stb && !s_ack && (r_to_cnt == c_CNT_MAX);

    // Count unacknowledged strobe cycles, and restart on any ack, idle strobe or timeout.
    always_ff @(posedge clk) begin
        if (rst || !w_owner_stb || s_ack || w_timeout_hit) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_CNT_W'(1);
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Forward the owner onto the slave port. The non-owner sees all zeros.
    always_comb begin
        s_adr    = 32'h0;
        s_dat_o  = 32'h0;
        s_we     = 1'b0;
        s_sel    = 4'h0;
        s_stb    = 1'b0;
        s_cyc    = 1'b0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_dat_i = 32'h0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_dat_i = 32'h0;
        case (r_state)
            ST_OWN0: begin
                s_adr    = m0_adr;
                s_dat_o  = m0_dat_o;
                s_we     = m0_we;
                s_sel    = m0_sel;
                s_cyc    = m0_cyc;
                s_stb    = w_owner_stb & ~w_timeout_hit;
                m0_ack   = s_ack;
                m0_err   = w_timeout_hit;
                m0_dat_i = s_dat_i;
            end
            ST_OWN1: begin
                s_adr    = m1_adr;
                s_dat_o  = m1_dat_o;
                s_we     = m1_we;
                s_sel    = m1_sel;
                s_cyc    = m1_cyc;
                s_stb    = w_owner_stb & ~w_timeout_hit;
                m1_ack   = s_ack;
                m1_err   = w_timeout_hit;
                m1_dat_i = s_dat_i;
            end
            default: begin
                // IDLE: the bus is parked, and a spurious s_ack reaches nobody.
            end
        endcase
    end

    assign grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter2
// Description : Directed self-checking bench for wb_arbiter2. Expected values
//               are hand-computed. Define WB_ARB_TIMEOUT_EN to exercise the
//               timeout build with TIMEOUT_CYCLES = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_dat_o, m0_dat_i;
    logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
    logic [3:0]  m0_sel;
    logic [31:0] m1_adr, m1_dat_o, m1_dat_i;
    logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
    logic [3:0]  m1_sel;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic        s_we, s_stb, s_cyc, s_ack;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned c_TIMEOUT = 8;
`else
    localparam int unsigned c_TIMEOUT = 255;
`endif

    wb_arbiter2 #(
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .FIRST_PRIO     (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_adr   (m0_adr),
        .m0_dat_o (m0_dat_o),
        .m0_dat_i (m0_dat_i),
        .m0_we    (m0_we),
        .m0_sel   (m0_sel),
        .m0_stb   (m0_stb),
        .m0_cyc   (m0_cyc),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_adr   (m1_adr),
        .m1_dat_o (m1_dat_o),
        .m1_dat_i (m1_dat_i),
        .m1_we    (m1_we),
        .m1_sel   (m1_sel),
        .m1_stb   (m1_stb),
        .m1_cyc   (m1_cyc),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .s_adr    (s_adr),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_we     (s_we),
        .s_sel    (s_sel),
        .s_stb    (s_stb),
        .s_cyc    (s_cyc),
        .s_ack    (s_ack),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after inputs change.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Bound the run in case of a hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m0_adr = '0; m0_dat_o = '0; m0_we = 1'b0; m0_sel = '0; m0_stb = 1'b0; m0_cyc = 1'b0;
        m1_adr = '0; m1_dat_o = '0; m1_we = 1'b0; m1_sel = '0; m1_stb = 1'b0; m1_cyc = 1'b0;
        s_dat_i = 32'h1234_5678; s_ack = 1'b0;

        // ---- reset state ----
        repeat (3) step();
        settle();
        check("rst grant",    32'(grant),  32'd0);
        check("rst s_cyc",    32'(s_cyc),  32'd0);
        check("rst s_stb",    32'(s_stb),  32'd0);
        check("rst s_we",     32'(s_we),   32'd0);
        check("rst s_adr",    s_adr,       32'd0);
        check("rst s_dat_o",  s_dat_o,     32'd0);
        check("rst s_sel",    32'(s_sel),  32'd0);
        check("rst m0_ack",   32'(m0_ack), 32'd0);
        check("rst m1_ack",   32'(m1_ack), 32'd0);
        check("rst m0_err",   32'(m0_err), 32'd0);
        check("rst m1_err",   32'(m1_err), 32'd0);
        check("rst m0_dat_i", m0_dat_i,    32'd0);
        check("rst m1_dat_i", m1_dat_i,    32'd0);
        rst = 1'b0;

        // ---- m0 single read, slave acks two cycles after stb ----
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'hFFD1_0004; m0_we = 1'b0; m0_sel = 4'hF;
        settle();
        check("rd grant pre",  32'(grant),  32'd0);
        check("rd s_stb pre",  32'(s_stb),  32'd0);
        check("rd m0_ack pre", 32'(m0_ack), 32'd0);
        step(); settle();
        check("rd grant",  32'(grant), 32'd1);
        check("rd s_adr",  s_adr,      32'hFFD1_0004);
        check("rd s_cyc",  32'(s_cyc), 32'd1);
        check("rd s_stb",  32'(s_stb), 32'd1);
        check("rd s_sel",  32'(s_sel), 32'hF);
        check("rd s_we",   32'(s_we),  32'd0);
        step(); settle();
        check("rd wait ack", 32'(m0_ack), 32'd0);
        step();
        s_ack = 1'b1; s_dat_i = 32'hA5A5_0001;
        settle();
        check("rd m0_ack",   32'(m0_ack), 32'd1);
        check("rd m0_dat_i", m0_dat_i,    32'hA5A5_0001);
        check("rd m1_ack",   32'(m1_ack), 32'd0);
        check("rd m1_dat_i", m1_dat_i,    32'd0);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        check("rd drop s_cyc", 32'(s_cyc), 32'd0);
        check("rd drop grant", 32'(grant), 32'd1);
        step();
        s_ack = 1'b1;
        settle();
        check("idle grant",      32'(grant),  32'd0);
        check("idle spur m0ack", 32'(m0_ack), 32'd0);
        check("idle spur m1ack", 32'(m1_ack), 32'd0);
        check("idle s_stb",      32'(s_stb),  32'd0);
        s_ack = 1'b0;

        // ---- simultaneous requests right after reset, then round robin ----
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h1000_0010;
        settle();
        check("rr grant pre", 32'(grant), 32'd0);
        step(); settle();
        check("rr first m0", 32'(grant), 32'd1);
        check("rr s_adr m0", s_adr,      32'h0000_0100);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step(); settle();
        check("rr gap grant", 32'(grant), 32'd0);
        check("rr gap s_cyc", 32'(s_cyc), 32'd0);
        step(); settle();
        check("rr then m1",  32'(grant), 32'd2);
        check("rr s_adr m1", s_adr,      32'h1000_0010);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step(); settle();
        check("rr idle2", 32'(grant), 32'd0);
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step(); settle();
        check("rr back m0", 32'(grant), 32'd1);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        step(); settle();

        // ---- m1 holds three beats while m0 keeps requesting ----
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            s_ack = 1'b1; s_dat_i = 32'hBEEF_0000 + 32'(i);
            settle();
            check("mb grant",    32'(grant),  32'd2);
            check("mb m1_ack",   32'(m1_ack), 32'd1);
            check("mb m1_dat_i", m1_dat_i,    32'hBEEF_0000 + 32'(i));
            check("mb m0_ack",   32'(m0_ack), 32'd0);
            step();
        end
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        settle();
        check("mb drop grant", 32'(grant), 32'd2);
        step(); settle();
        check("mb gap grant", 32'(grant), 32'd0);
        step(); settle();
        check("mb m0 granted", 32'(grant), 32'd1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step(); settle();

        // ---- reset while m1 owns the bus with stb high ----
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step(); settle();
        check("rm grant", 32'(grant), 32'd2);
        check("rm s_stb", 32'(s_stb), 32'd1);
        rst = 1'b1; s_ack = 1'b1;
        step(); settle();
        check("rm s_cyc",  32'(s_cyc),  32'd0);
        check("rm s_stb0", 32'(s_stb),  32'd0);
        check("rm grant0", 32'(grant),  32'd0);
        check("rm m1_ack", 32'(m1_ack), 32'd0);
        rst = 1'b0; s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step(); settle();
        check("rm first prio", 32'(grant), 32'd1);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        step(); step();

        // ---- m0 write to a slave that never acks ----
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'hFFD0_0000;
        m0_dat_o = 32'h1122_3344; m0_sel = 4'hF;
        step(); settle();
        check("st s_we",    32'(s_we), 32'd1);
        check("st s_adr",   s_adr,     32'hFFD0_0000);
        check("st s_dat_o", s_dat_o,   32'h1122_3344);
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 0; k < 10; k++) begin
            check("to m0_err", 32'(m0_err), (k == 8) ? 32'd1 : 32'd0);
            check("to s_stb",  32'(s_stb),  (k == 8) ? 32'd0 : 32'd1);
            check("to m1_err", 32'(m1_err), 32'd0);
            step(); settle();
        end
        check("to grant kept", 32'(grant), 32'd1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step(); step();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step(); settle();
        for (int k = 0; k < 8; k++) begin
            check("ta m0_err", 32'(m0_err), 32'd0);
            check("ta m0_ack", 32'(m0_ack), 32'd0);
            step(); settle();
        end
        s_ack = 1'b1;
        settle();
        check("ta ack wins",  32'(m0_ack), 32'd1);
        check("ta no err",    32'(m0_err), 32'd0);
        check("ta s_stb",     32'(s_stb),  32'd1);
        s_ack = 1'b0;
`else
        for (int k = 0; k < 1000; k++) begin
            check("ns m0_err", 32'(m0_err), 32'd0);
            check("ns grant",  32'(grant),  32'd1);
            step(); settle();
        end
        check("ns s_stb held", 32'(s_stb), 32'd1);
`endif
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step(); step(); settle();
        check("end grant", 32'(grant), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
